uart_tx_arb: RTL



---
 rtl/uart_tx_arb_if.sv | 35 +++
 rtl/uart_tx_arb.sv | 117 +++++++++++
 2 files changed

// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - producer/transmitter handshake bundle for uart_tx_arb (req_last when UART_TX_ARB_PACKET_EN)
interface uart_tx_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
`ifdef UART_TX_ARB_PACKET_EN
    logic [N_REQ-1:0]   req_last;
`endif
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic               arb_busy;
    logic               start_err;

    modport master (
        output req_valid, req_data,
`ifdef UART_TX_ARB_PACKET_EN
        output req_last,
`endif
        output tx_busy,
        input  req_ready, grant, tx_start, tx_data, arb_busy, start_err
    );

    modport slave (
        input  req_valid, req_data,
`ifdef UART_TX_ARB_PACKET_EN
        input  req_last,
`endif
        input  tx_busy,
        output req_ready, grant, tx_start, tx_data, arb_busy, start_err
    );
endinterface

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART transmitter; UART_TX_ARB_PACKET_EN adds req_last packet locking
module uart_tx_arb #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_arb_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] eff_valid;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    int               j;

`ifdef UART_TX_ARB_PACKET_EN
    logic             locked;

    // While a packet is open only the current owner may win.
    always_comb begin
        eff_valid = bus.req_valid;
        if (locked) begin
            eff_valid = bus.req_valid & (ONE << ptr);
        end
    end
`else
    always_comb begin
        eff_valid = bus.req_valid;
    end
`endif

    // Scan upward from ptr+1; the last requester checked is ptr itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!win_found && eff_valid[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= PTR_RST;
            cnt           <= '0;
            bus.req_ready <= '0;
            bus.grant     <= '0;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= '0;
            bus.arb_busy  <= 1'b0;
            bus.start_err <= 1'b0;
`ifdef UART_TX_ARB_PACKET_EN
            locked        <= 1'b0;
`endif
        end else begin
            bus.req_ready <= '0;
            bus.tx_start  <= 1'b0;
            bus.start_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found && !bus.tx_busy) begin
                        bus.grant     <= ONE << win_idx;
                        bus.req_ready <= ONE << win_idx;
                        bus.tx_data   <= bus.req_data[{win_idx, 3'b000} +: 8];
                        bus.arb_busy  <= 1'b1;
                        ptr           <= win_idx;
                        state         <= ISSUE;
`ifdef UART_TX_ARB_PACKET_EN
                        locked        <= !bus.req_last[win_idx];
`endif
                    end
                end
                ISSUE: begin
                    bus.tx_start <= 1'b1;
                    cnt          <= '0;
                    state        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Transmitter never acknowledged: resend the same latched byte.
                        bus.start_err <= 1'b1;
                        state         <= ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        bus.grant    <= '0;
                        bus.arb_busy <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
